// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants for pair_reg_file.
//   - op encodings for the write/arithmetic port
//   - snapshot serializer state enum
//   - pair indices for the default six-pair configuration
package reg_file_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_WR8  = 3'd1;
  localparam logic [2:0] OP_WR16 = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_DEC  = 3'd4;
  localparam logic [2:0] OP_INC2 = 3'd5;
  localparam logic [2:0] OP_ADD  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic {
    SNAP_IDLE  = 1'b0,
    SNAP_SHIFT = 1'b1
  } snap_state_e;

  localparam int unsigned PAIR_BC = 0;
  localparam int unsigned PAIR_DE = 1;
  localparam int unsigned PAIR_HL = 2;
  localparam int unsigned PAIR_WZ = 3;
  localparam int unsigned PAIR_PC = 4;
  localparam int unsigned PAIR_SP = 5;

endpackage

// File: rtl/snapshot_serializer.sv
// snapshot_serializer: captures the flattened register array into a shadow
// buffer and streams it out MSB-first, one bit per clock.
//   clk, rst   : clock, synchronous active-high reset
//   flat_in    : array contents, byte 0 in the top WIDTH bits
//   snap_req   : start a frame (ignored while a frame is in flight)
//   snap_busy  : frame in progress (registered)
//   serial_out : frame bit stream, 0 when idle (registered)
//   start      : high during the first bit of each frame (registered)
module snapshot_serializer
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 12,
  parameter bit          AUTO  = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH*DEPTH-1:0]   flat_in,
  input  logic                     snap_req,
  output logic                     snap_busy,
  output logic                     serial_out,
  output logic                     start
);

  localparam int unsigned TOTAL = WIDTH * DEPTH;
  localparam int unsigned CW    = $clog2(TOTAL);

  snap_state_e      state_q, state_d;
  logic [TOTAL-1:0] shadow_q, shadow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             serial_q, serial_d;
  logic             start_q, start_d;
  logic             capture;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SNAP_IDLE;
      shadow_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      serial_q <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      serial_q <= serial_d;
      start_q  <= start_d;
    end
  end

  // Next state; bit 0 goes straight to serial_d on capture, so the shadow
  // holds the remaining bits left-aligned.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    serial_d = 1'b0;
    start_d  = 1'b0;
    capture  = 1'b0;
    case (state_q)
      SNAP_IDLE: begin
        if (snap_req || AUTO) capture = 1'b1;
      end
      SNAP_SHIFT: begin
        if (cnt_q == CW'(TOTAL - 1)) begin
          state_d = SNAP_IDLE;
          if (AUTO) capture = 1'b1;
        end else begin
          cnt_d    = cnt_q + CW'(1);
          serial_d = shadow_q[TOTAL-1];
          shadow_d = {shadow_q[TOTAL-2:0], 1'b0};
        end
      end
      default: state_d = SNAP_IDLE;
    endcase
    if (capture) begin
      state_d  = SNAP_SHIFT;
      shadow_d = {flat_in[TOTAL-2:0], 1'b0};
      cnt_d    = '0;
      serial_d = flat_in[TOTAL-1];
      start_d  = 1'b1;
    end
    busy_d = (state_d == SNAP_SHIFT);
  end

  assign snap_busy  = busy_q;
  assign serial_out = serial_q;
  assign start      = start_q;

endmodule

// File: rtl/pair_reg_file.sv
// pair_reg_file: byte-addressed register file organised as register pairs,
// with two combinational read ports, one write/pair-arithmetic port, a
// registered zero flag and a debug snapshot serializer.
//   clk, rst             : clock, synchronous active-high reset
//   op, wr_sel, data_in  : write/arithmetic port (see reg_file_pkg ops)
//   rd_sel_x, rd_ext_x   : read index, 1 = pair / 0 = zero-extended byte
//   data_out_a/b         : read data (combinational)
//   pair_zero            : last INC/DEC/INC2/ADD result was zero
//   snap_req/snap_busy/serial_out/start : snapshot stream
module pair_reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned NUM_PAIRS  = 6,
  parameter bit          AUTO_SNAP  = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [2:0]                       op,
  input  logic [$clog2(2*NUM_PAIRS)-1:0]   wr_sel,
  input  logic [2*WORD_WIDTH-1:0]          data_in,
  input  logic [$clog2(2*NUM_PAIRS)-1:0]   rd_sel_a,
  input  logic [$clog2(2*NUM_PAIRS)-1:0]   rd_sel_b,
  input  logic                             rd_ext_a,
  input  logic                             rd_ext_b,
  output logic [2*WORD_WIDTH-1:0]          data_out_a,
  output logic [2*WORD_WIDTH-1:0]          data_out_b,
  output logic                             pair_zero,
  input  logic                             snap_req,
  output logic                             snap_busy,
  output logic                             serial_out,
  output logic                             start
);

  localparam int unsigned NB = 2 * NUM_PAIRS;
  localparam int unsigned SW = $clog2(NB);
  localparam int unsigned PW = 2 * WORD_WIDTH;

  logic [WORD_WIDTH-1:0] bytes_q [NB];
  logic [WORD_WIDTH-1:0] bytes_d [NB];
  logic                  pair_zero_q, pair_zero_d;

  logic [SW-1:0]         wr_hi, wr_lo;
  logic                  wr_ok, pair_op;
  logic [PW-1:0]         wr_pair, pair_res;
  logic [NB*WORD_WIDTH-1:0] flat;

  // Array and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bytes_q     <= '{default: '0};
      pair_zero_q <= 1'b0;
    end else begin
      bytes_q     <= bytes_d;
      pair_zero_q <= pair_zero_d;
    end
  end

  // Write / pair-arithmetic port; out-of-range indices leave everything alone
  always_comb begin
    bytes_d     = bytes_q;
    pair_zero_d = pair_zero_q;
    wr_hi       = wr_sel & ~SW'(1);
    wr_lo       = wr_sel | SW'(1);
    wr_ok       = 32'(wr_sel) < NB;
    wr_pair     = {bytes_q[wr_hi], bytes_q[wr_lo]};
    pair_res    = '0;
    pair_op     = 1'b0;
    case (op)
      OP_INC:  begin pair_res = wr_pair + PW'(1); pair_op = 1'b1; end
      OP_DEC:  begin pair_res = wr_pair - PW'(1); pair_op = 1'b1; end
      OP_INC2: begin pair_res = wr_pair + PW'(2); pair_op = 1'b1; end
      OP_ADD:  begin pair_res = wr_pair + data_in; pair_op = 1'b1; end
      default: ;
    endcase
    if (wr_ok) begin
      if (op == OP_WR8) begin
        bytes_d[wr_sel] = data_in[WORD_WIDTH-1:0];
      end else if (op == OP_WR16) begin
        bytes_d[wr_hi] = data_in[PW-1:WORD_WIDTH];
        bytes_d[wr_lo] = data_in[WORD_WIDTH-1:0];
      end else if (pair_op) begin
        bytes_d[wr_hi] = pair_res[PW-1:WORD_WIDTH];
        bytes_d[wr_lo] = pair_res[WORD_WIDTH-1:0];
        pair_zero_d    = (pair_res == '0);
      end
    end
  end

  // Read mux shared by both ports
  function automatic logic [PW-1:0] rd_word(input logic [SW-1:0] sel,
                                            input logic ext);
    logic [PW-1:0] r;
    r = '0;
    if (32'(sel) < NB) begin
      if (ext) r = {bytes_q[sel & ~SW'(1)], bytes_q[sel | SW'(1)]};
      else     r = {{WORD_WIDTH{1'b0}}, bytes_q[sel]};
    end
    return r;
  endfunction

  always_comb begin
    data_out_a = rd_word(rd_sel_a, rd_ext_a);
    data_out_b = rd_word(rd_sel_b, rd_ext_b);
  end

  // Byte 0 lands in the top bits so the serializer emits it first
  always_comb begin
    flat = '0;
    for (int i = 0; i < int'(NB); i++)
      flat[(int'(NB) - 1 - i) * int'(WORD_WIDTH) +: WORD_WIDTH] = bytes_q[i];
  end

  assign pair_zero = pair_zero_q;

  snapshot_serializer #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (NB),
    .AUTO  (AUTO_SNAP)
  ) u_snap (
    .clk        (clk),
    .rst        (rst),
    .flat_in    (flat),
    .snap_req   (snap_req),
    .snap_busy  (snap_busy),
    .serial_out (serial_out),
    .start      (start)
  );

endmodule

// File: tb/tb_pair_reg_file.sv
// Bench for pair_reg_file: behavioural model of the byte array, flag and
// snapshot frame, compared every cycle, plus directed literal checks.
module tb_pair_reg_file;

  localparam int NB = 12;
  localparam int FRAME = 96;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  op;
  logic [3:0]  wr_sel, rd_sel_a, rd_sel_b;
  logic [15:0] data_in;
  logic        rd_ext_a, rd_ext_b, snap_req;
  logic [15:0] data_out_a, data_out_b;
  logic        pair_zero, snap_busy, serial_out, start;

  logic [15:0] a2, b2;
  logic        pz2, busy2, ser2, start2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pair_reg_file dut (
    .clk(clk), .rst(rst), .op(op), .wr_sel(wr_sel), .data_in(data_in),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .rd_ext_a(rd_ext_a),
    .rd_ext_b(rd_ext_b), .data_out_a(data_out_a), .data_out_b(data_out_b),
    .pair_zero(pair_zero), .snap_req(snap_req), .snap_busy(snap_busy),
    .serial_out(serial_out), .start(start)
  );

  pair_reg_file #(.AUTO_SNAP(1'b1)) dut_auto (
    .clk(clk), .rst(rst), .op(3'd0), .wr_sel(4'd0), .data_in(16'd0),
    .rd_sel_a(4'd0), .rd_sel_b(4'd0), .rd_ext_a(1'b0), .rd_ext_b(1'b0),
    .data_out_a(a2), .data_out_b(b2), .pair_zero(pz2), .snap_req(1'b0),
    .snap_busy(busy2), .serial_out(ser2), .start(start2)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int m_b [NB];
  int m_pz;
  int m_pos;            // frame bit being shown next cycle, -1 = idle
  bit m_frame [FRAME];
  bit chk_en = 1'b0;
  int pv, r, p;

  function automatic int exp_rd(input int sel, input bit ext);
    if (sel >= NB) return 0;
    if (ext) return m_b[sel & ~1] * 256 + m_b[sel | 1];
    return m_b[sel];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      foreach (m_b[i]) m_b[i] = 0;
      m_pz  = 0;
      m_pos = -1;
    end else begin
      // capture uses contents before this edge's write
      if (m_pos < 0) begin
        if (snap_req) begin
          for (int k = 0; k < FRAME; k++)
            m_frame[k] = bit'((m_b[k / 8] >> (7 - k % 8)) & 1);
          m_pos = 0;
        end
      end else if (m_pos == FRAME - 1) begin
        m_pos = -1;
      end else begin
        m_pos++;
      end
      if (int'(wr_sel) < NB) begin
        p  = int'(wr_sel) & ~1;
        pv = m_b[p] * 256 + m_b[p + 1];
        case (op)
          3'd1: m_b[wr_sel] = int'(data_in[7:0]);
          3'd2: begin
            m_b[p]     = int'(data_in[15:8]);
            m_b[p + 1] = int'(data_in[7:0]);
          end
          3'd3, 3'd4, 3'd5, 3'd6: begin
            if (op == 3'd3)      r = pv + 1;
            else if (op == 3'd4) r = pv + 65535;
            else if (op == 3'd5) r = pv + 2;
            else                 r = pv + int'(data_in);
            r          = r % 65536;
            m_b[p]     = r / 256;
            m_b[p + 1] = r % 256;
            m_pz       = (r == 0) ? 1 : 0;
          end
          default: ;
        endcase
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_a", data_out_a, exp_rd(int'(rd_sel_a), rd_ext_a));
      check("rd_b", data_out_b, exp_rd(int'(rd_sel_b), rd_ext_b));
      check("pair_zero", pair_zero, m_pz);
      check("snap_busy", snap_busy, (m_pos >= 0) ? 1 : 0);
      check("start", start, (m_pos == 0) ? 1 : 0);
      check("serial_out", serial_out, (m_pos >= 0) ? m_frame[m_pos] : 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [3:0] s,
                       input logic [15:0] d);
    op = o; wr_sel = s; data_in = d;
    cyc();
    op = 3'd0;
    #1;
  endtask

  logic [7:0] pat;
  int last, n_start;

  initial begin
    rst = 1'b1; op = 3'd0; wr_sel = '0; data_in = '0;
    rd_sel_a = '0; rd_sel_b = '0; rd_ext_a = 1'b0; rd_ext_b = 1'b0;
    snap_req = 1'b0;
    cyc(); cyc();
    chk_en = 1'b1;
    check("rst_pz", pair_zero, 0);
    check("rst_busy", snap_busy, 0);
    check("rst_serial", serial_out, 0);
    check("rst_start", start, 0);
    rst = 1'b0;

    // WR16 with read-during-write returning the old value
    op = 3'd2; wr_sel = 4'd2; data_in = 16'h1234;
    rd_sel_a = 4'd2; rd_ext_a = 1'b1;
    #1 check("rdw_old", data_out_a, 16'h0000);
    cyc(); op = 3'd0;
    rd_sel_b = 4'd3; rd_ext_b = 1'b0;
    #1;
    check("wr16_pair", data_out_a, 16'h1234);
    check("byte_read", data_out_b, 16'h0034);

    // Pair 0 wraparound and flag behaviour
    rd_sel_a = 4'd0; rd_ext_a = 1'b1;
    do_op(3'd2, 4'd0, 16'hFFFF);
    do_op(3'd3, 4'd0, 16'h0000);
    check("inc_wrap", data_out_a, 16'h0000);
    check("inc_pz", pair_zero, 1);
    do_op(3'd4, 4'd1, 16'h0000);   // odd index still targets pair 0
    check("dec_wrap", data_out_a, 16'hFFFF);
    check("dec_pz", pair_zero, 0);
    do_op(3'd5, 4'd0, 16'h0000);
    check("inc2_wrap", data_out_a, 16'h0001);
    do_op(3'd1, 4'd1, 16'h0000);
    check("wr8_pz_hold", pair_zero, 0);
    check("wr8_low", data_out_a, 16'h0000);
    do_op(3'd7, 4'd0, 16'h5555);
    check("rsvd_nop", data_out_a, 16'h0000);

    // ADD to pair 10, then out-of-range accesses
    rd_sel_a = 4'd10;
    do_op(3'd2, 4'd10, 16'h7FFF);
    do_op(3'd6, 4'd11, 16'h8001);
    check("add_wrap", data_out_a, 16'h0000);
    check("add_pz", pair_zero, 1);
    do_op(3'd1, 4'd12, 16'h00AA);
    rd_sel_b = 4'd13; rd_ext_b = 1'b0;
    #1 check("oor_byte", data_out_b, 16'h0000);
    rd_ext_b = 1'b1;
    #1 check("oor_pair", data_out_b, 16'h0000);
    do_op(3'd3, 4'd14, 16'h0000);
    check("oor_inc_pz", pair_zero, 1);
    do_op(3'd2, 4'd4, 16'hABCD);
    check("wr16_pz_hold", pair_zero, 1);

    // Snapshot frame with byte0 = A5
    rst = 1'b1; cyc(); rst = 1'b0;
    do_op(3'd1, 4'd0, 16'h00A5);
    pat = 8'hA5;
    snap_req = 1'b1; cyc(); snap_req = 1'b0;
    #1;
    for (int k = 0; k < FRAME; k++) begin
      check("frame_busy", snap_busy, 1);
      check("frame_start", start, (k == 0) ? 1 : 0);
      if (k < 8) check("frame_bit", serial_out, pat[7 - k]);
      else       check("frame_zero", serial_out, 0);
      if (k == 10) begin op = 3'd1; wr_sel = 4'd0;  data_in = 16'h00FF; end
      if (k == 11) begin op = 3'd1; wr_sel = 4'd11; data_in = 16'h00FF; end
      if (k == 12) op = 3'd0;
      if (k == 20) snap_req = 1'b1;
      if (k == 21) snap_req = 1'b0;
      cyc(); #1;
    end
    check("frame_end_busy", snap_busy, 0);
    check("frame_end_start", start, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      check("no_extra_frame", snap_busy, 0);
    end

    // Reset in bit 40 of a frame
    snap_req = 1'b1; cyc(); snap_req = 1'b0;
    repeat (40) cyc();
    rd_sel_a = 4'd0; rd_ext_a = 1'b1;
    rst = 1'b1; cyc(); #1;
    check("midrst_busy", snap_busy, 0);
    check("midrst_serial", serial_out, 0);
    check("midrst_start", start, 0);
    check("midrst_data", data_out_a, 16'h0000);
    rst = 1'b0; cyc(); #1;
    check("midrst_idle", snap_busy, 0);

    // Free-running instance: start every FRAME cycles, busy never drops
    rst = 1'b1; cyc(); rst = 1'b0;
    last = -1; n_start = 0;
    for (int c = 0; c < 300; c++) begin
      cyc(); #1;
      if (start2) begin
        if (last >= 0) check("auto_period", c - last, FRAME);
        last = c;
        n_start++;
      end
      if (n_start > 0) check("auto_busy", busy2, 1);
    end
    check("auto_starts", n_start, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
